// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with enable, validated parallel load and terminal-count pulse.
// Define BCD_SATURATE_EN to hold at all-9s / all-0s instead of wrapping.
module bcd_updown_counter_n #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic         all_nine;
  logic         all_zero;
  logic         load_ok;

  // Ripple carry/borrow across digits: a digit steps only when every lower digit is at its limit.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] digit;
    up_val  = count_q;
    dn_val  = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    load_ok = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        up_val[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end
      if (borrow) begin
        dn_val[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      end
      carry  = carry & (digit == 4'd9);
      borrow = borrow & (digit == 4'd0);
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
    all_nine = carry;
    all_zero = borrow;
  end

  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (dir) begin
        tc_d = all_nine;
`ifdef BCD_SATURATE_EN
        if (!all_nine) begin
          count_d = up_val;
        end
`else
        count_d = up_val;
`endif
      end else begin
        tc_d = all_zero;
`ifdef BCD_SATURATE_EN
        if (!all_zero) begin
          count_d = dn_val;
        end
`else
        count_d = dn_val;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n: a 4-digit instance driven from a vector table and
// a 2-digit instance for wrap/saturation sequences.
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        rst;

  logic        en4, dir4, load4;
  logic [15:0] load_val4, count4;
  logic        tc4, err4;

  logic        en2, dir2, load2;
  logic [7:0]  load_val2, count2;
  logic        tc2, err2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .dir(dir4), .load(load4), .load_val(load_val4),
    .count(count4), .tc(tc4), .load_err(err4)
  );

  bcd_updown_counter_n #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .dir(dir2), .load(load2), .load_val(load_val2),
    .count(count2), .tc(tc2), .load_err(err2)
  );

  typedef struct {
    logic        load;
    logic        en;
    logic        dir;
    logic [15:0] load_val;
    logic [15:0] exp_count;
    logic        exp_tc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, input logic e, input logic d, input logic [15:0] lv,
                     input logic [15:0] ec, input logic et, input logic ee);
    vec_t v;
    v.load = l; v.en = e; v.dir = d; v.load_val = lv;
    v.exp_count = ec; v.exp_tc = et; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step2(input logic l, input logic e, input logic d, input logic [7:0] lv);
    load2 = l; en2 = e; dir2 = d; load_val2 = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {en4, dir4, load4, load_val4} = '0;
    {en2, dir2, load2, load_val2} = '0;

    // Vector table (4 digits), starting from the reset state.
    add(1, 0, 0, 16'h0123, 16'h0123, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h0124, 0, 0);
    add(1, 0, 0, 16'h0042, 16'h0042, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 16'h0000, 16'h0042, 0, 0);
    add(1, 1, 1, 16'h0500, 16'h0500, 0, 0);
    add(1, 0, 0, 16'h0042, 16'h0042, 0, 0);
    add(1, 1, 1, 16'h00A5, 16'h0042, 0, 1);
    add(0, 0, 0, 16'h0000, 16'h0042, 0, 0);
    add(1, 0, 0, 16'h1000, 16'h1000, 0, 0);
    add(0, 1, 0, 16'h0000, 16'h0999, 0, 0);
    add(0, 1, 0, 16'h0000, 16'h0998, 0, 0);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0);
`ifdef BCD_SATURATE_EN
    add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
    add(0, 1, 1, 16'h0000, 16'h0001, 0, 0);
    add(1, 0, 0, 16'h9999, 16'h9999, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h9999, 1, 0);
`else
    add(0, 1, 0, 16'h0000, 16'h9999, 1, 0);
    add(0, 1, 1, 16'h0000, 16'h0000, 1, 0);
    add(1, 0, 0, 16'h9999, 16'h9999, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h0000, 1, 0);
`endif
    add(1, 0, 0, 16'h0199, 16'h0199, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h0200, 0, 0);
    add(1, 0, 1, 16'hA000, 16'h0200, 0, 1);
    add(0, 1, 0, 16'h0000, 16'h0199, 0, 0);
    add(1, 0, 0, 16'h0909, 16'h0909, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h0910, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count4", 32'(count4), 32'h0);
    chk("reset_tc4", 32'(tc4), 32'h0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      load4 = vecs[k].load; en4 = vecs[k].en; dir4 = vecs[k].dir;
      load_val4 = vecs[k].load_val;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", k), 32'(count4), 32'(vecs[k].exp_count));
      chk($sformatf("vec%0d_tc", k), 32'(tc4), 32'(vecs[k].exp_tc));
      chk($sformatf("vec%0d_err", k), 32'(err4), 32'(vecs[k].exp_err));
    end

    // Asynchronous reset between edges, then resume counting.
    load4 = 1'b1; en4 = 1'b0; load_val4 = 16'h0123;
    @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count4), 32'h0123);
    load4 = 1'b0; en4 = 1'b1; dir4 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count4), 32'h0);
    chk("async_rst_tc", 32'(tc4), 32'h0);
    chk("async_rst_err", 32'(err4), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", 32'(count4), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(count4), 32'h0001);
    en4 = 1'b0;

    // 2-digit wrap / saturation sequences.
    step2(1, 0, 1, 8'h99);
    chk("d2_load99", 32'(count2), 32'h99);
`ifdef BCD_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      step2(0, 1, 1, 8'h00);
      chk($sformatf("d2_sat%0d_count", i), 32'(count2), 32'h99);
      chk($sformatf("d2_sat%0d_tc", i), 32'(tc2), 32'h1);
    end
    step2(0, 1, 0, 8'h00);
    chk("d2_down_count", 32'(count2), 32'h98);
    chk("d2_down_tc", 32'(tc2), 32'h0);
`else
    step2(0, 1, 1, 8'h00);
    chk("d2_wrap_count", 32'(count2), 32'h00);
    chk("d2_wrap_tc", 32'(tc2), 32'h1);
    step2(0, 1, 1, 8'h00);
    chk("d2_after_count", 32'(count2), 32'h01);
    chk("d2_after_tc", 32'(tc2), 32'h0);
    step2(0, 1, 0, 8'h00);
    chk("d2_dn_count", 32'(count2), 32'h00);
    chk("d2_dn_tc", 32'(tc2), 32'h0);
    step2(0, 1, 0, 8'h00);
    chk("d2_dnwrap_count", 32'(count2), 32'h99);
    chk("d2_dnwrap_tc", 32'(tc2), 32'h1);
`endif
    step2(1, 1, 1, 8'h9A);
    chk("d2_bad_count", 32'(count2), (`ifdef BCD_SATURATE_EN 32'h98 `else 32'h99 `endif));
    chk("d2_bad_err", 32'(err2), 32'h1);
    chk("d2_bad_tc", 32'(tc2), 32'h0);
    step2(0, 0, 1, 8'h00);
    chk("d2_err_clear", 32'(err2), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised N-digit BCD up/down counter. Next generation of the team's 2-digit BCD counter.
- Adds a count enable, synchronous parallel load with BCD validation, a registered terminal-count pulse, and optional saturation.
- Sits between the prescaler tick generator and the seven-segment multiplexer; each output nibble feeds one display digit.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable (one-cycle tick from prescaler); counter holds when low.
- dir  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD load value; nibble i = digit i, nibble 0 = ones.
- count  output  4*DIGITS  current BCD count; nibble 0 = ones.
- tc  output  1  registered terminal-count pulse on wrap (or limit hit when saturating).
- load_err  output  1  registered pulse: load rejected because load_val held a non-BCD nibble.

Behaviour:
- Reset (rst high, async): count = 0, tc = 0, load_err = 0. Holds while rst is high. The first edge after release uses the normal priority below.
- Priority per rising edge: load > en > hold.
- load = 1 and every nibble of load_val is <= 9: count <= load_val; tc <= 0; load_err <= 0. en is ignored that cycle.
- load = 1 and any nibble of load_val is > 9: count unchanged; load_err <= 1 for exactly one cycle; tc <= 0.
- load = 0, en = 1, dir = 1 (up):
  - Digit 0 increments. Digit i (i > 0) increments only when digits 0..i-1 are all 9.
  - A digit at 9 that receives a carry becomes 0.
  - All digits 9 -> all digits 0, with tc <= 1.
- load = 0, en = 1, dir = 0 (down):
  - Digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that receives a borrow becomes 9.
  - All digits 0 -> all digits 9, with tc <= 1.
- load = 0, en = 0: count holds; tc <= 0; load_err <= 0.
- Timing:
  - tc and load_err are registered. They are high in the same cycle the new count appears, for one cycle only.
  - tc is never asserted on a non-wrapping step.
- dir may change on any cycle; the value sampled at the edge governs that step. No extra latency.
- Latency: count reflects a step or load on the first rising edge where it is sampled; one cycle per operation.
- Invariant: every nibble of count is always 0..9.
- Carry/borrow chain is combinational over all DIGITS. Single-cycle for DIGITS <= 8 at target clock.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined:
  - Counting up at all-9s, or down at all-0s, leaves count unchanged (no wrap).
  - tc <= 1 for each enabled step attempted at the limit.
  - Load behaviour unchanged.
- Undefined: wrap-around exactly as in Behaviour; no saturation logic synthesised.

Test Plan:
- Reset mid-count: DIGITS=4, count=0123; assert rst asynchronously between edges -> count=0000, tc=0, load_err=0 immediately. After release with en=1, dir=1 -> count=0001.
- Up wrap: DIGITS=2, load 99, en=1, dir=1 -> next edge count=00, tc=1 for one cycle; following edge count=01, tc=0.
- Down cascade: DIGITS=4, load 1000, en=1, dir=0 -> 0999, then 0998, tc=0 throughout. Load 0000, one step down -> 9999, tc=1.
- Enable gating and load priority:
  - en=0 for 5 cycles at 0042 -> count stays 0042.
  - load=1, en=1, load_val=0500 -> count=0500, no increment that cycle.
- Invalid load: count=0042, load=1, load_val=0x00A5 -> count stays 0042, load_err=1 for one cycle, tc=0.
- With BCD_SATURATE_EN: DIGITS=2 at 99, en=1, dir=1 for 3 cycles -> count stays 99, tc=1 each cycle. Then dir=0 -> count=98, tc=0.
